// File: rtl/bnn_param_loader.sv
// Nibble-stream parameter loader for the 8-8-4 BNN core: frames of sync, per-neuron
// {weight lo, weight hi, threshold} nibbles and an XOR checksum become neuron bank writes.
module bnn_param_loader #(
    parameter int         NUM_NEURONS = 20,
    parameter logic [3:0] SYNC_NIB    = 4'hA
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       load_en,
    input  logic [3:0] nib_in,
    output logic       wr_en,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_weight,
    output logic [3:0] wr_thresh,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       params_valid
);

    localparam logic [4:0] LAST_ADDR = 5'(NUM_NEURONS - 1);

    typedef enum logic [2:0] {
        IDLE,
        W_LO,
        W_HI,
        THR,
        CHK
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       accept;
    logic [4:0] addr_cnt;
    logic [3:0] chk_acc;
    logic [7:0] weight_buf;

    assign accept = ena && load_en;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                IDLE:    state_nxt = (nib_in == SYNC_NIB) ? W_LO : IDLE;
                W_LO:    state_nxt = W_HI;
                W_HI:    state_nxt = THR;
                THR:     state_nxt = (addr_cnt == LAST_ADDR) ? CHK : W_LO;
                CHK:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Stage boundary: accepted nibble -> registered bank write and frame status
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_cnt     <= '0;
            chk_acc      <= '0;
            weight_buf   <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_weight    <= '0;
            wr_thresh    <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            params_valid <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        // The sync nibble itself is not part of the checksum.
                        if (nib_in == SYNC_NIB) begin
                            addr_cnt     <= '0;
                            chk_acc      <= '0;
                            err          <= 1'b0;
                            params_valid <= 1'b0;
                        end
                    end
                    W_LO: begin
                        weight_buf[3:0] <= nib_in;
                        chk_acc         <= chk_acc ^ nib_in;
                    end
                    W_HI: begin
                        weight_buf[7:4] <= nib_in;
                        chk_acc         <= chk_acc ^ nib_in;
                    end
                    THR: begin
                        chk_acc   <= chk_acc ^ nib_in;
                        wr_en     <= 1'b1;
                        wr_addr   <= addr_cnt;
                        wr_weight <= weight_buf;
                        wr_thresh <= nib_in;
                        if (addr_cnt != LAST_ADDR) begin
                            addr_cnt <= addr_cnt + 5'd1;
                        end
                    end
                    CHK: begin
                        done <= 1'b1;
                        if (nib_in == chk_acc) begin
                            params_valid <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bnn_param_loader.sv
// Scoreboard bench for bnn_param_loader: stimulus pushes expected writes/results,
// a negedge monitor pops and compares them when the DUT strobes wr_en or done.
module tb_bnn_param_loader;

    localparam int         NUM  = 20;
    localparam logic [3:0] SYNC = 4'hA;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ena = 1'b0;
    logic       load_en = 1'b0;
    logic [3:0] nib_in = 4'h0;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_weight;
    logic [3:0] wr_thresh;
    logic       busy;
    logic       done;
    logic       err;
    logic       params_valid;

    bnn_param_loader #(.NUM_NEURONS(NUM), .SYNC_NIB(SYNC)) dut (
        .clk(clk), .reset(reset), .ena(ena), .load_en(load_en), .nib_in(nib_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_weight(wr_weight), .wr_thresh(wr_thresh),
        .busy(busy), .done(done), .err(err), .params_valid(params_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] a;
        logic [7:0] w;
        logic [3:0] t;
    } wr_t;

    wr_t        wq[$];
    logic [1:0] dq[$];
    logic [7:0] wt[NUM];
    logic [3:0] th[NUM];

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_pre = 0;
    int sync_pre = 0;
    logic wr_en_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            chk("wr_en_single_cycle", {31'd0, wr_en_prev}, 32'd0);
            if (wq.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = wq.pop_front();
                chk("wr_addr", {27'd0, wr_addr}, {27'd0, e.a});
                chk("wr_weight", {24'd0, wr_weight}, {24'd0, e.w});
                chk("wr_thresh", {28'd0, wr_thresh}, {28'd0, e.t});
            end
        end
        wr_en_prev <= wr_en;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_low_at_done", {31'd0, busy}, 32'd0);
            if (dq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [1:0] d;
                d = dq.pop_front();
                chk("done_err", {31'd0, err}, {31'd0, d[1]});
                chk("done_params_valid", {31'd0, params_valid}, {31'd0, d[0]});
            end
        end
    end

    task automatic send_nib(input logic [3:0] n);
        @(negedge clk);
        last_pre = cyc;
        ena = 1'b1;
        load_en = 1'b1;
        nib_in = n;
        @(posedge clk);
        #1;
    endtask

    task automatic stop_stream();
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Hold the stream for k edges, either with load_en low or with ena low.
    task automatic pause(input int k, input bit drop_ena);
        @(negedge clk);
        ena = drop_ena ? 1'b0 : 1'b1;
        load_en = drop_ena ? 1'b1 : 1'b0;
        nib_in = SYNC;
        repeat (k) @(posedge clk);
        #1;
        chk("busy_during_pause", {31'd0, busy}, 32'd1);
    endtask

    task automatic load_set(input int s);
        for (int n = 0; n < NUM; n++) begin
            if (s == 0) begin
                wt[n] = 8'((n * 13) % 256);
                th[n] = 4'(n % 16);
            end else begin
                wt[n] = 8'hAA ^ 8'(n);
                th[n] = (n % 2 == 0) ? SYNC : 4'(n);
            end
        end
    endtask

    task automatic send_frame(input bit bad, input int abort_after, input bit paused);
        logic [3:0] acc;
        acc = 4'h0;
        send_nib(SYNC);
        sync_pre = last_pre;
        chk("busy_after_sync", {31'd0, busy}, 32'd1);
        chk("err_cleared_by_sync", {31'd0, err}, 32'd0);
        chk("pv_cleared_by_sync", {31'd0, params_valid}, 32'd0);
        for (int n = 0; n < NUM; n++) begin
            send_nib(wt[n][3:0]);
            send_nib(wt[n][7:4]);
            if (paused) pause(5, 1'b0);
            if (paused && n == 10) pause(3, 1'b1);
            send_nib(th[n]);
            wq.push_back('{a: 5'(n), w: wt[n], t: th[n]});
            acc = acc ^ wt[n][3:0] ^ wt[n][7:4] ^ th[n];
            if (n == abort_after) return;
        end
        send_nib(acc ^ (bad ? 4'h1 : 4'h0));
        dq.push_back({bad, ~bad});
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 10 && done_cnt < target; i++) @(posedge clk);
        #1;
        chk("done_count", done_cnt, target);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {16'd0, wr_en, wr_addr, wr_weight, wr_thresh, done, err, params_valid},
            32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Good frame at full rate
        load_set(0);
        send_frame(1'b0, -1, 1'b0);
        stop_stream();
        wait_done(1);
        chk("done_latency", done_cyc - sync_pre, 62);
        chk("t1_params_valid", {31'd0, params_valid}, 32'd1);
        chk("t1_err", {31'd0, err}, 32'd0);

        // Corrupted checksum
        send_frame(1'b1, -1, 1'b0);
        stop_stream();
        wait_done(2);
        chk("t2_err", {31'd0, err}, 32'd1);
        chk("t2_params_valid", {31'd0, params_valid}, 32'd0);

        // Non-sync nibbles in IDLE are ignored
        send_nib(4'h3);
        chk("idle_busy_3", {31'd0, busy}, 32'd0);
        send_nib(4'h5);
        chk("idle_busy_5", {31'd0, busy}, 32'd0);
        send_nib(4'hF);
        chk("idle_busy_F", {31'd0, busy}, 32'd0);
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Paused frame; its sync also clears the previous err
        send_frame(1'b0, -1, 1'b1);
        stop_stream();
        wait_done(3);
        chk("t4_params_valid", {31'd0, params_valid}, 32'd1);

        // Reset after neuron 7's threshold
        send_frame(1'b0, 7, 1'b0);
        @(negedge clk);
        load_en = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_outputs", {16'd0, wr_en, wr_addr, wr_weight, wr_thresh, done, err, params_valid},
            32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        send_frame(1'b0, -1, 1'b0);
        stop_stream();
        wait_done(4);
        chk("t5_params_valid", {31'd0, params_valid}, 32'd1);

        // Back-to-back frames whose data contains sync values
        load_set(1);
        send_frame(1'b0, -1, 1'b0);
        send_frame(1'b0, -1, 1'b0);
        stop_stream();
        wait_done(6);
        chk("t6_params_valid", {31'd0, params_valid}, 32'd1);
        chk("t6_err", {31'd0, err}, 32'd0);

        repeat (5) @(posedge clk);
        #1;
        chk("write_queue_drained", wq.size(), 0);
        chk("done_queue_drained", dq.size(), 0);
        chk("total_writes", wr_cnt, 128);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bnn_param_loader.md
# bnn_param_loader

Upstream configuration stage for the 8-8-4 BNN core: deserialises a nibble stream from the bidirectional pins into per-neuron weight bytes and threshold nibbles and writes them into the neuron parameter bank, one neuron per write. A frame carries a sync nibble, all neuron parameters and an XOR checksum. The block reports busy, completion, checksum error and whether the currently loaded parameter set is verified.

## Interface
- NUM_NEURONS, 20, neurons per frame (layer1 8 + layer2 8 + layer3 4); address width is 5 bits.
- SYNC_NIB, 4'hA, frame start nibble.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ena  in  1  design enable; when low, no nibble is consumed and all state holds.
- load_en  in  1  nibble strobe (uio_in[3]); the nibble is sampled on every clk edge where ena && load_en.
- nib_in  in  4  data nibble (uio_in[7:4]).
- wr_en  out  1  one-cycle parameter write strobe.
- wr_addr  out  5  neuron index 0..NUM_NEURONS-1.
- wr_weight  out  8  {high nibble, low nibble}; bit i is the weight for input i.
- wr_thresh  out  4  neuron threshold.
- busy  out  1  high while a frame is in progress (state other than IDLE).
- done  out  1  one-cycle pulse after the checksum nibble is accepted.
- err  out  1  sticky checksum mismatch flag; cleared by a new sync or by reset.
- params_valid  out  1  last frame completed with a good checksum.

## Operation
- An accepted nibble is defined as `ena && load_en` at a clk edge. Every state transition happens only on an accepted nibble.
- FSM states are IDLE, W_LO, W_HI, THR and CHK.
- IDLE:
  - Accepted nibble == SYNC_NIB: go to W_LO, clear addr counter, checksum accumulator, err and params_valid.
  - Any other nibble: ignored; stay in IDLE.
- W_LO: latch nibble into weight[3:0], XOR into checksum, go to W_HI.
- W_HI: latch nibble into weight[7:4], XOR into checksum, go to THR.
- THR:
  - XOR nibble into checksum.
  - Register wr_en=1, wr_addr=counter, wr_weight, wr_thresh=nibble.
  - If counter == NUM_NEURONS-1, go to CHK; else increment counter and go to W_LO.
- CHK: compare the nibble with the accumulated checksum (sync nibble excluded).
  - Equal: params_valid=1.
  - Not equal: err=1.
  - In both cases pulse done and return to IDLE.
- Frame length is 1 + 3·NUM_NEURONS + 1 = 62 accepted nibbles.
- Writes are committed per neuron as the frame progresses; there is no shadow bank. params_valid is the only indicator that the bank is coherent.
- A SYNC_NIB value received mid-frame is treated as data, not as a restart.
- Counter never exceeds NUM_NEURONS-1; there is no wrap-around path.

## Timing
- Reset (synchronous) puts the FSM in IDLE, counter and checksum at 0, and wr_en, wr_addr, wr_weight, wr_thresh, busy, done, err and params_valid all at 0.
- Reset mid-frame aborts the frame: no further writes; already-written neurons keep their new values; params_valid=0.
- wr_en/wr_addr/wr_weight/wr_thresh are registered and valid in the cycle after the THR nibble edge; wr_en is high for exactly one cycle. Data outputs hold their last values afterwards.
- done, err and params_valid update in the cycle after the CHK nibble edge; done is high for one cycle.
- busy goes high in the cycle after the sync nibble edge and goes low in the same cycle done pulses.
- Pausing (load_en or ena low for any number of cycles) freezes all state; the stream resumes with the next accepted nibble. No timeout.
- Maximum throughput is one nibble per cycle, i.e. one neuron write every 3 cycles.

## Test plan
- Full frame with weights[n]=n·13 mod 256 and thresh[n]=n mod 16, correct checksum, load_en held high -> 20 wr_en pulses with addr 0..19 and matching data; done pulses 62 cycles after sync; params_valid=1; err=0.
- Same frame with checksum nibble XOR 4'h1 -> all 20 writes occur; done pulses; err=1; params_valid=0. A subsequent sync clears err.
- Nibbles 4'h3, 4'h5, 4'hF in IDLE, then sync -> no writes before the sync; busy stays 0 until the sync is accepted.
- Frame with load_en dropped for 5 cycles after every W_HI nibble, and ena low for 3 cycles once -> identical writes and result to the unpaused run, only delayed.
- Reset asserted after neuron 7's THR nibble -> 8 writes (addr 0..7), then all outputs 0 and FSM in IDLE. A fresh full frame then completes with params_valid=1.
- Two back-to-back frames with no gap, where frame 2 data contains SYNC_NIB values -> 40 writes total; done pulses twice; params_valid=1 after frame 2.
